// File: rtl/fr_adder_pkg.sv
// Shared helpers for the prefix fraction adder: level count and pipeline register placement.
package fr_adder_pkg;

  // Ceiling log2, with clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Number of Kogge-Stone levels needed to cover a W+1 bit G/P vector.
  function automatic int unsigned fr_prefix_levels(input int unsigned w);
    return clog2(w + 1);
  endfunction

  // 1 when a register closes the group that ends at this layer.
  // Layers 0..l are split into pipe groups whose sizes differ by at most 1, larger groups first.
  function automatic bit fr_stage_end(input int unsigned layer, input int unsigned l,
                                      input int unsigned pipe);
    int unsigned n;
    int unsigned p;
    int unsigned acc;
    bit          hit;
    n   = l + 1;
    p   = (pipe == 0) ? 1 : pipe;
    acc = 0;
    hit = 1'b0;
    for (int unsigned g = 0; g < 32; g++) begin
      if (g < p) begin
        acc = acc + (n / p) + ((g < (n % p)) ? 1 : 0);
        if (acc > 0 && (acc - 1) == layer) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  // 1-based pipeline stage index of the register that follows this layer.
  function automatic int unsigned fr_stage_num(input int unsigned layer, input int unsigned l,
                                               input int unsigned pipe);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned j = 0; j < 64; j++) begin
      if (j <= layer && fr_stage_end(j, l, pipe)) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fr_prefix_level.sv
// One Kogge-Stone prefix level: combines each position with the one DIST below it.
module fr_prefix_level #(
  parameter int unsigned WV   = 25,
  parameter int unsigned DIST = 1
) (
  input  logic [WV-1:0] g_in,
  input  logic [WV-1:0] p_in,
  output logic [WV-1:0] g_out,
  output logic [WV-1:0] p_out
);

  // Low DIST positions have no partner and must keep their propagate bit.
  localparam logic [WV-1:0] LOW_MASK = (WV'(1) << DIST) - WV'(1);

  // Positions below DIST see shifted-in zeros, so G passes through and P is kept by the mask.
  assign g_out = g_in | (p_in & (g_in << DIST));
  assign p_out = p_in & ((p_in << DIST) | LOW_MASK);

endmodule

// File: rtl/fr_prefix_adder_pipe.sv
// Pipelined Kogge-Stone fraction adder with subtract, carry-in, side-band tag and valid/ready.
module fr_prefix_adder_pipe
  import fr_adder_pkg::*;
#(
  parameter int unsigned W     = 24,
  parameter int unsigned PIPE  = 3,
  parameter int unsigned TAG_W = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned L  = fr_prefix_levels(W);
  localparam int unsigned WV = W + 1;

  // Reject pipeline depths that cannot be mapped onto the L+1 compute layers.
  if (PIPE < 1 || PIPE > L + 1) begin : g_bad_pipe
    $error("fr_prefix_adder_pipe: PIPE out of range 1..L+1");
  end

  // Per-stage occupancy and ready chain; an empty stage always accepts, so bubbles collapse.
  for (genvar k = 1; k <= PIPE; k++) begin : stg
    logic vld;
    logic rdy;
    logic vld_in;

    if (k == 1) begin : g_vin_first
      assign vld_in = in_valid;
    end else begin : g_vin_next
      assign vld_in = stg[k-1].vld;
    end

    if (k == PIPE) begin : g_rdy_last
      assign rdy = ~vld | out_ready;
    end else begin : g_rdy_next
      assign rdy = ~vld | stg[k+1].rdy;
    end

    // Stage valid bit: advances when this stage may load, holds otherwise.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        vld <= 1'b0;
      end else if (rdy) begin
        vld <= vld_in;
      end
    end
  end

  assign in_ready  = stg[1].rdy;
  assign out_valid = stg[PIPE].vld;

  // Compute layers: layer 0 is operand prep and G/P, layers 1..L are prefix levels.
  // *_c is the layer's combinational result, *_o is what the next layer sees.
  for (genvar n = 0; n <= L; n++) begin : lay
    logic [W:0]       g_c;
    logic [W:0]       p_c;
    logic [W:0]       po_c;
    logic [TAG_W-1:0] tag_c;
    logic [W:0]       g_o;
    logic [W:0]       p_o;
    logic [W:0]       po_o;
    logic [TAG_W-1:0] tag_o;

    if (n == 0) begin : g_gen
      logic [W-1:0] b_x;
      assign b_x   = in_sub ? ~in_b : in_b;
      assign g_c   = {in_a & b_x, in_sub | in_cin};
      assign p_c   = {in_a ^ b_x, 1'b0};
      assign po_c  = p_c;
      assign tag_c = in_tag;
    end else begin : g_pre
      fr_prefix_level #(
        .WV  (WV),
        .DIST(2 ** (n - 1))
      ) u_level (
        .g_in (lay[n-1].g_o),
        .p_in (lay[n-1].p_o),
        .g_out(g_c),
        .p_out(p_c)
      );
      assign po_c  = lay[n-1].po_o;
      assign tag_c = lay[n-1].tag_o;
    end

    if (n < L && fr_stage_end(n, L, PIPE)) begin : g_reg
      localparam int unsigned K = fr_stage_num(n, L, PIPE);
      logic [W:0]       g_q;
      logic [W:0]       p_q;
      logic [W:0]       po_q;
      logic [TAG_W-1:0] tag_q;

      // Intermediate G/P/Porig/tag register closing this group, loaded with its stage.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          g_q   <= '0;
          p_q   <= '0;
          po_q  <= '0;
          tag_q <= '0;
        end else if (stg[K].rdy) begin
          g_q   <= g_c;
          p_q   <= p_c;
          po_q  <= po_c;
          tag_q <= tag_c;
        end
      end

      assign g_o   = g_q;
      assign p_o   = p_q;
      assign po_o  = po_q;
      assign tag_o = tag_q;
    end else begin : g_thru
      assign g_o   = g_c;
      assign p_o   = p_c;
      assign po_o  = po_c;
      assign tag_o = tag_c;
    end
  end

  // Final prefix P and the constant-zero Porig[0] carry no result information.
  logic unused_p;
  assign unused_p = ^{lay[L].p_o, lay[L].po_o[0]};

  // Output register: sum XOR and carry-out, held while downstream stalls.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_tag  <= '0;
    end else if (stg[PIPE].rdy) begin
      out_sum  <= lay[L].po_o[W:1] ^ lay[L].g_o[W-1:0];
      out_cout <= lay[L].g_o[W];
      out_tag  <= lay[L].tag_o;
    end
  end

endmodule
